// File: rtl/mux_scan_sel_pkg.sv
// mux_scan_sel shared definitions.
// Mode encoding and the select-width helper.
package mux_scan_sel_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Rotating priority finder: first enabled channel
// strictly after cur_sel, wrapping modulo N_CH.
module mux_next_ch
  import mux_scan_sel_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [SEL_W-1:0] cur_sel,
  output logic [SEL_W-1:0] next_sel,
  output logic             wrapped,
  output logic             none_found
);

  int               w_base;
  logic [SEL_W-1:0] w_idx;

  // Out-of-range selects search from channel 0 onward.
  always_comb begin
    next_sel   = cur_sel;
    none_found = 1'b1;
    w_idx      = '0;
    w_base     = (int'(cur_sel) >= N_CH) ? N_CH - 1 : int'(cur_sel);
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = SEL_W'((w_base + k) % N_CH);
      if (none_found && ch_mask[w_idx]) begin
        none_found = 1'b0;
        next_sel   = w_idx;
      end
    end
    wrapped = !none_found && (next_sel <= cur_sel);
  end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with manual and
// round-robin scan modes, masking and wrap strobe.
module mux_scan_sel
  import mux_scan_sel_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int W       = 1,
  parameter int DWELL_W = 16,
  parameter int SEL_W   = clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   d,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel_in,
  input  logic                sel_load,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [W-1:0]        out,
  output logic                out_valid,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                wrap
);

  logic [W-1:0]       r_out;
  logic               r_valid;
  logic [SEL_W-1:0]   r_sel;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;

  logic [W-1:0]       w_ch [N_CH];
  logic               w_in_range;
  logic               w_scan;
  logic [DWELL_W-1:0] w_dm1;
  logic               w_last;
  logic [SEL_W-1:0]   w_next;
  logic               w_wrapped;
  logic               w_none;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_ch[k] = d[k*W +: W];
  end

  assign w_in_range = {1'b0, r_sel} < (SEL_W+1)'(N_CH);
  assign w_scan     = (mode == logic'(MODE_SCAN));
  assign w_dm1      = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign w_last     = (r_cnt >= w_dm1);

  mux_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next (
    .ch_mask    (ch_mask),
    .cur_sel    (r_sel),
    .next_sel   (w_next),
    .wrapped    (w_wrapped),
    .none_found (w_none)
  );

  // Sample data, track dwell count and step the select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else if (en) begin
      r_out   <= w_in_range ? w_ch[r_sel] : '0;
      r_valid <= w_in_range && ch_mask[r_sel];
      r_wrap  <= 1'b0;
      if (!w_scan) begin
        r_cnt <= '0;
        if (sel_load) r_sel <= sel_in;
      end else if (w_last) begin
        r_cnt <= '0;
        if (!w_none) begin
          r_sel  <= w_next;
          r_wrap <= w_wrapped;
        end
      end else begin
        r_cnt <= r_cnt + DWELL_W'(1);
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign cur_sel   = r_sel;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: N_CH=6 (non power of two),
// W=4, behavioural model plus directed literal checks.
module tb_mux_scan_sel;

  localparam int NC = 6;
  localparam int WD = 4;
  localparam int DW = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NC*WD-1:0] d = '0;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic [SW-1:0] sel_in = '0;
  logic          sel_load = 1'b0;
  logic [NC-1:0] ch_mask = '0;
  logic [DW-1:0] dwell = '0;
  logic [WD-1:0] out;
  logic          out_valid;
  logic [SW-1:0] cur_sel;
  logic          wrap;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  mux_scan_sel #(
    .N_CH    (NC),
    .W       (WD),
    .DWELL_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .en        (en),
    .mode      (mode),
    .sel_in    (sel_in),
    .sel_load  (sel_load),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .out       (out),
    .out_valid (out_valid),
    .cur_sel   (cur_sel),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Reference: current channel, cycles spent on it,
  // and the registered outputs.
  int       m_sel = 0;
  int       m_age = 0;
  logic [WD-1:0] m_out = '0;
  bit       m_valid = 1'b0;
  bit       m_wrap = 1'b0;

  // First enabled channel above old, else lowest enabled,
  // -1 when nothing is enabled.
  function automatic int next_on(input int old,
                                 input logic [NC-1:0] m);
    for (int c = 0; c < NC; c++)
      if (c > old && m[c]) return c;
    for (int c = 0; c < NC; c++)
      if (m[c]) return c;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int dd;
    int old;
    int nx;
    if (rst) begin
      m_sel = 0; m_age = 0; m_out = '0;
      m_valid = 1'b0; m_wrap = 1'b0;
    end else if (en) begin
      dd  = (dwell == 0) ? 1 : int'(dwell);
      old = m_sel;
      if (old < NC) begin
        m_out   = d[old*WD +: WD];
        m_valid = ch_mask[old];
      end else begin
        m_out   = '0;
        m_valid = 1'b0;
      end
      m_wrap = 1'b0;
      if (mode == 1'b0) begin
        m_age = 0;
        if (sel_load) m_sel = int'(sel_in);
      end else begin
        m_age++;
        if (m_age >= dd) begin
          m_age = 0;
          nx = next_on(old, ch_mask);
          if (nx >= 0) begin
            m_sel  = nx;
            m_wrap = (nx <= old);
          end
        end
      end
    end else begin
      m_wrap = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      n_vec++;
      if (out !== m_out || out_valid !== m_valid ||
          cur_sel !== SW'(m_sel) || wrap !== m_wrap) begin
        n_err++;
        $display("FAIL model t=%0t got out=%h v=%b sel=%0d wrap=%b want out=%h v=%b sel=%0d wrap=%b",
                 $time, out, out_valid, cur_sel, wrap,
                 m_out, m_valid, m_sel, m_wrap);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps;
    checking = 1'b1;
    #1 rst = 1'b1;
    repeat (2) tick();
    chk("rst_out", 32'(out), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'(cur_sel), 0);
    chk("rst_wrap", 32'(wrap), 0);

    // manual load: ch k holds k+1
    rst = 1'b0; en = 1'b1; mode = 1'b0;
    ch_mask = 6'h3F; d = 24'h654321;
    sel_in = 3'd5; sel_load = 1'b1;
    tick();
    chk("man_sel5", 32'(cur_sel), 5);
    sel_load = 1'b0;
    tick();
    chk("man_out5", 32'(out), 6);
    chk("man_val5", 32'(out_valid), 1);

    // masked-off channel
    ch_mask = 6'h37; sel_in = 3'd3; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    tick();
    chk("mask_out3", 32'(out), 4);
    chk("mask_val3", 32'(out_valid), 0);

    // out-of-range select
    sel_in = 3'd7; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("oor_sel", 32'(cur_sel), 7);
    tick();
    chk("oor_out", 32'(out), 0);
    chk("oor_val", 32'(out_valid), 0);

    // full scan, dwell 3
    sel_in = 3'd0; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    ch_mask = 6'h3F; dwell = 4'd3; mode = 1'b1;
    wraps = 0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      wraps += int'(wrap);
      if (i == 3) chk("scan_first", 32'(cur_sel), 1);
      if (i == 17) chk("scan_ch5", 32'(cur_sel), 5);
    end
    chk("scan_back0", 32'(cur_sel), 0);
    chk("scan_wrap", 32'(wrap), 1);
    chk("scan_nwraps", 32'(wraps), 1);

    // two channels, dwell 0 acts as 1
    ch_mask = 6'h24; dwell = 4'd0;
    tick(); chk("alt_a", 32'({wrap, cur_sel}), 32'h2);
    tick(); chk("alt_b", 32'({wrap, cur_sel}), 32'h5);
    tick(); chk("alt_c", 32'({wrap, cur_sel}), 32'hA);
    tick(); chk("alt_d", 32'({wrap, cur_sel}), 32'h5);

    // empty mask
    ch_mask = 6'h00; dwell = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("empty_hold", 32'({wrap, cur_sel}), 32'h5);
    end
    chk("empty_val", 32'(out_valid), 0);

    // async reset mid-scan
    ch_mask = 6'h3F; dwell = 4'd5;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("arst_all", 32'({out, out_valid, cur_sel, wrap}), 0);
    #1 rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("arst_out", 32'(out), 1);
      chk("arst_sel", 32'(cur_sel), (i == 5) ? 1 : 0);
    end

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      tick();
      rst      = ($urandom_range(0, 59) == 0);
      en       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel_in   = SW'($urandom_range(0, 7));
      sel_load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0)
        ch_mask = NC'($urandom);
      if ($urandom_range(0, 23) == 0)
        dwell = ($urandom_range(0, 3) == 0) ?
                DW'($urandom) : DW'($urandom_range(0, 3));
      d = (NC*WD)'($urandom);
    end
    rst = 1'b0;
    tick();
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
